// File: rtl/pipelined_carry_adder.sv
// Pipelined add/subtract: WIDTH bits split into CHUNK-bit ripple slices, one slice per stage.
// Latency: STAGES = WIDTH/CHUNK register levels (capture included); one operation per unstalled cycle.
// Backpressure: none besides stall, which freezes every register and refuses the input that cycle.
module pipelined_carry_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             stall,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  // WIDTH must be a multiple of CHUNK; STAGES is derived and not a parameter.
  localparam int STAGES = WIDTH / CHUNK;

  // Each stage k consumes the low chunk of its remaining operands and forwards
  // the rest (input skew), while its result chunk is appended above the results
  // of the earlier stages (output deskew), so a finished word leaves the last
  // stage in one piece.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand bits still to be added when the operation reaches this stage.
    localparam int IN_W   = WIDTH - k * CHUNK;
    // Result bits known once this stage has registered.
    localparam int DONE_W = (k + 1) * CHUNK;

    logic [IN_W-1:0]   a_src;
    logic [IN_W-1:0]   b_src;
    logic              carry_in;
    logic              valid_in;
    logic [CHUNK-1:0]  chunk_sum;
    logic [CHUNK:0]    c;
    logic [DONE_W-1:0] sum_d;
    logic [DONE_W-1:0] sum_q;
    logic              valid_q;
    logic              carry_q;

    if (k == 0) begin : g_src
      // Subtraction is A + ~B + 1; cin only matters in add mode.
      assign a_src    = a;
      assign b_src    = sub ? ~b : b;
      assign carry_in = sub ? 1'b1 : cin;
      assign valid_in = in_valid;
      assign sum_d    = chunk_sum;
    end else begin : g_src
      assign a_src    = g_stage[k-1].g_rem.a_rem;
      assign b_src    = g_stage[k-1].g_rem.b_rem;
      assign carry_in = g_stage[k-1].carry_q;
      assign valid_in = g_stage[k-1].valid_q;
      assign sum_d    = {chunk_sum, g_stage[k-1].sum_q};
    end

    // Bit-level ripple across this stage's chunk; c[CHUNK-1] is the carry into the chunk MSB.
    always_comb begin
      c         = '0;
      chunk_sum = '0;
      c[0]      = carry_in;
      for (int i = 0; i < CHUNK; i++) begin
        chunk_sum[i] = a_src[i] ^ b_src[i] ^ c[i];
        c[i+1]       = (a_src[i] & b_src[i]) | (c[i] & (a_src[i] ^ b_src[i]));
      end
    end

    // Stage register: valid, inter-stage carry and accumulated result; holds on stall.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else if (!stall) begin
        valid_q <= valid_in;
        carry_q <= c[CHUNK];
        sum_q   <= sum_d;
      end
    end

    if (k < STAGES - 1) begin : g_rem
      logic [IN_W-CHUNK-1:0] a_rem;
      logic [IN_W-CHUNK-1:0] b_rem;

      // Skew register: pass the not-yet-added operand chunks to the next stage.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_rem <= '0;
          b_rem <= '0;
        end else if (!stall) begin
          a_rem <= a_src[IN_W-1:CHUNK];
          b_rem <= b_src[IN_W-1:CHUNK];
        end
      end
    end

    if (k == STAGES - 1) begin : g_last
      logic ovf_q;

      // Signed overflow: carry into the word MSB differs from carry out of it.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (!stall) begin
          ovf_q <= c[CHUNK] ^ c[CHUNK-1];
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].valid_q;
  assign sum       = g_stage[STAGES-1].sum_q;
  assign cout      = g_stage[STAGES-1].carry_q;
  assign ovf       = g_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// Bench for pipelined_carry_adder: 16/4 main instance under random traffic, stalls and resets,
// plus 4/1 and 4/2 instances driven with every operand combination back-to-back.
// Expected results come from signed/unsigned integer arithmetic and an issue-order queue.
module tb_pipelined_carry_adder;

  localparam int W = 16;
  localparam int C = 4;
  localparam int S = W / C;

  logic         clk;
  logic         rst_n;
  logic         in_valid, sub, cin, stall;
  logic [W-1:0] a, b;
  logic         out_valid, cout, ovf;
  logic [W-1:0] sum;

  // Shared stimulus for the two small instances.
  logic       s_valid, s_sub, s_cin, s_stall;
  logic [3:0] s_a, s_b;
  logic       v1, c1, o1, v2, c2, o2;
  logic [3:0] sum1, sum2;

  int n_tests = 0;
  int n_fail  = 0;

  pipelined_carry_adder #(.WIDTH(W), .CHUNK(C)) u_main (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .sub(sub), .a(a), .b(b),
    .cin(cin), .stall(stall), .out_valid(out_valid), .sum(sum), .cout(cout), .ovf(ovf)
  );

  pipelined_carry_adder #(.WIDTH(4), .CHUNK(1)) u_w4c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .sub(s_sub), .a(s_a), .b(s_b),
    .cin(s_cin), .stall(s_stall), .out_valid(v1), .sum(sum1), .cout(c1), .ovf(o1)
  );

  pipelined_carry_adder #(.WIDTH(4), .CHUNK(2)) u_w4c2 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .sub(s_sub), .a(s_a), .b(s_b),
    .cin(s_cin), .stall(s_stall), .out_valid(v2), .sum(sum2), .cout(c2), .ovf(o2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  // Reference arithmetic on w-bit operands using plain integers.
  function automatic void ref_model(input int w, input int av, input int bv, input int cv,
                                    input int sv, output int s, output int co, output int ov);
    int lim, sa, sb, res, sres;
    lim = 1 << w;
    sa  = (av >= lim / 2) ? av - lim : av;
    sb  = (bv >= lim / 2) ? bv - lim : bv;
    if (sv != 0) begin
      res  = av - bv;
      co   = (av >= bv) ? 1 : 0;
      sres = sa - sb;
    end else begin
      res  = av + bv + cv;
      co   = (res >= lim) ? 1 : 0;
      sres = sa + sb + cv;
    end
    s  = res & (lim - 1);
    ov = (sres < -(lim / 2) || sres > lim / 2 - 1) ? 1 : 0;
  endfunction

  typedef struct {
    int           tag;
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  exp_t         q[$];
  int           adv = 0;
  logic         exp_v, exp_c, exp_o;
  logic [W-1:0] exp_s;
  bit           chk_data;

  // Directed operations carry their hand-computed results.
  bit           ovr_en = 0;
  logic [W-1:0] ovr_s;
  logic         ovr_c, ovr_o;

  task automatic model_reset();
    q.delete();
    exp_v    = 1'b0;
    exp_s    = '0;
    exp_c    = 1'b0;
    exp_o    = 1'b0;
    chk_data = 1'b1;
  endtask

  // One clock of the main instance: update the expectation for this edge, then compare.
  task automatic step();
    int   s_, c_, o_;
    exp_t e;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else if (!stall) begin
      adv++;
      if (in_valid) begin
        if (ovr_en) begin
          e.s = ovr_s;
          e.c = ovr_c;
          e.o = ovr_o;
        end else begin
          ref_model(W, int'(a), int'(b), int'(cin), int'(sub), s_, c_, o_);
          e.s = s_[W-1:0];
          e.c = c_[0];
          e.o = o_[0];
        end
        e.tag = adv;
        q.push_back(e);
      end
      if (q.size() > 0 && q[0].tag + S - 1 == adv) begin
        e        = q.pop_front();
        exp_v    = 1'b1;
        exp_s    = e.s;
        exp_c    = e.c;
        exp_o    = e.o;
        chk_data = 1'b1;
      end else begin
        exp_v    = 1'b0;
        chk_data = 1'b0;
      end
    end
    #1;
    check_eq("out_valid", out_valid, exp_v);
    if (chk_data) begin
      check_eq("sum", sum, exp_s);
      check_eq("cout", cout, exp_c);
      check_eq("ovf", ovf, exp_o);
    end
  endtask

  task automatic drive_rand(input logic v, input logic st);
    in_valid = v;
    stall    = st;
    sub      = 1'($urandom_range(0, 1));
    cin      = 1'($urandom_range(0, 1));
    a        = W'($urandom);
    b        = W'($urandom);
  endtask

  task automatic check_reset_now(input string tag);
    check_eq({tag, "_valid"}, out_valid, 0);
    check_eq({tag, "_sum"}, sum, 0);
    check_eq({tag, "_cout"}, cout, 0);
    check_eq({tag, "_ovf"}, ovf, 0);
  endtask

  // a, b, cin, sub, sum, cout, ovf
  logic [W-1:0] d_a [6] = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h0000, 16'h1234, 16'h0005};
  logic [W-1:0] d_b [6] = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h4321, 16'h0005};
  logic         d_ci[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic         d_sb[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [W-1:0] d_s [6] = '{16'h0000, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h5556, 16'h0000};
  logic         d_c [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic         d_o [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    int s_, c_, o_, idx;
    logic [6:0] got, want;

    rst_n = 1'b1;
    in_valid = 1'b0; sub = 1'b0; cin = 1'b0; stall = 1'b0; a = '0; b = '0;
    s_valid = 1'b0; s_sub = 1'b0; s_cin = 1'b0; s_stall = 1'b0; s_a = '0; s_b = '0;
    model_reset();

    // Power-on reset, checked between clock edges.
    #2 rst_n = 1'b0;
    #1 check_reset_now("por");
    check_eq("por_small_valid", {30'd0, v1, v2}, 0);
    step();
    step();
    rst_n = 1'b1;

    // Directed corner cases, back-to-back.
    ovr_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; stall = 1'b0;
      a = d_a[i]; b = d_b[i]; cin = d_ci[i]; sub = d_sb[i];
      ovr_s = d_s[i]; ovr_c = d_c[i]; ovr_o = d_o[i];
      step();
    end
    ovr_en = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < S + 1; i++) step();

    // Streaming with interleaved bubbles.
    for (int i = 0; i < 16; i++) begin
      drive_rand(1'($urandom_range(0, 3) != 0), 1'b0);
      step();
    end

    // Three operations in flight, then a 3-cycle stall with in_valid high.
    for (int i = 0; i < 3; i++) begin
      drive_rand(1'b1, 1'b0);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      drive_rand(1'b1, 1'b1);
      step();
    end
    in_valid = 1'b0; stall = 1'b0;
    for (int i = 0; i < S + 2; i++) step();

    // Reset while operations are in flight.
    for (int i = 0; i < 3; i++) begin
      drive_rand(1'b1, 1'b0);
      step();
    end
    rst_n = 1'b0;
    #1 check_reset_now("mid_rst");
    model_reset();
    drive_rand(1'b1, 1'b1);
    step();
    step();
    rst_n = 1'b1;
    in_valid = 1'b0; stall = 1'b0;
    for (int i = 0; i < S + 2; i++) step();

    // Random soak with stalls.
    for (int i = 0; i < 300; i++) begin
      drive_rand(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 4) == 0));
      step();
    end
    in_valid = 1'b0; stall = 1'b0;
    for (int i = 0; i < S + 1; i++) step();
    check_eq("drained", q.size(), 0);

    // Exhaustive 4-bit configurations: op index t encodes a, b, cin, sub.
    for (int t = 0; t < 1024 + 3; t++) begin
      if (t < 1024) begin
        s_valid = 1'b1;
        s_a     = t[3:0];
        s_b     = t[7:4];
        s_cin   = t[8];
        s_sub   = t[9];
      end else begin
        s_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      idx = t - 3;
      got = {v1, c1, o1, sum1};
      if (idx >= 0 && idx < 1024) begin
        ref_model(4, idx & 15, (idx >> 4) & 15, (idx >> 8) & 1, (idx >> 9) & 1, s_, c_, o_);
        want = {1'b1, c_[0], o_[0], s_[3:0]};
        check_eq("w4c1", got, want);
      end else begin
        check_eq("w4c1_valid", v1, 0);
      end
      idx = t - 1;
      got = {v2, c2, o2, sum2};
      if (idx >= 0 && idx < 1024) begin
        ref_model(4, idx & 15, (idx >> 4) & 15, (idx >> 8) & 1, (idx >> 9) & 1, s_, c_, o_);
        want = {1'b1, c_[0], o_[0], s_[3:0]};
        check_eq("w4c2", got, want);
      end else begin
        check_eq("w4c2_valid", v2, 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
